wall_clock: RTL and testbench
=============================

Name: wall_clock

Overview:
- Free-running cycle counter (wall clock) with an event-gated timestamp capture register.
- While is_active_i is high, the current count is latched to timestamp_o on every clock edge. When is_active_i is low, the last captured value is held.
- Sits beside event-generating/arbiter logic and provides time tags for events.

Parameters:
- SIZE, 32, width in bits of the internal counter and of timestamp_o.
- TICK_DIV, 1, prescaler: the counter advances once every TICK_DIV clk_i cycles; legal range 1..65535.

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- is_active_i  input  1  event/active qualifier; capture enable, sampled each rising edge.
- timestamp_o  output  SIZE  registered captured counter value.
- timestamp_valid_o  output  1  high for the cycle after each edge at which timestamp_o was loaded.
- counter_wrap_o  output  1  one-cycle pulse: the counter rolled over from all-ones to 0 at the preceding edge.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, and dominates all other inputs.
- Reset values: internal counter = 0, prescaler = 0, timestamp_o = 0, timestamp_valid_o = 0, counter_wrap_o = 0.
- Prescaler counts 0..TICK_DIV-1. Tick = (prescaler == TICK_DIV-1). With TICK_DIV=1, every cycle is a tick.
- Counter updates at each rising edge with reset_i=0 and tick=1: counter <= counter + 1, modulo 2^SIZE, wrapping from all-ones to 0.
- counter_wrap_o <= 1 at the edge where the counter goes all-ones -> 0; otherwise 0.
- Capture: at a rising edge with reset_i=0 and is_active_i=1, timestamp_o <= counter value before that edge's increment, and timestamp_valid_o <= 1.
- Hold: at an edge with is_active_i=0, timestamp_o holds and timestamp_valid_o <= 0.
- Capture latency: timestamp_o shows the value one edge after is_active_i is sampled high. Holding is_active_i high updates timestamp_o on every edge.
- Cycle numbering: edge k = k-th rising edge after the reset edge, k=1 first. With TICK_DIV=1, a capture at edge k yields timestamp_o = k-1.
- Reset during is_active_i=1: reset wins. timestamp_o=0 and counter=0. The first post-reset capture edge loads 0, then 1, 2, ...
- is_active_i toggling: no edge detection; the input is level-sensitive and no synchronizer is included, because the input is already synchronous.
- No combinational paths from inputs to outputs.

Optional Feature:
- Macro WALL_CLOCK_SATURATE_EN.
- Defined: the counter stops at all-ones instead of wrapping. counter_wrap_o instead pulses once, at the edge where the counter first reaches all-ones. Only reset clears saturation.
- Undefined: modulo-2^SIZE wrap behaviour as described in Behaviour.

Test Plan:
- Reset: assert reset_i for 1 cycle with is_active_i=0 -> timestamp_o=0, timestamp_valid_o=0, counter_wrap_o=0.
- Capture: release reset, hold is_active_i=0 for 2 edges, then high for 4 edges (edges 3..6) -> timestamp_o = 2,3,4,5 and timestamp_valid_o=1 each cycle. Drop is_active_i -> holds 5, valid=0.
- Idle gap: is_active_i=0 for 2 edges (7,8), then high at edge 9 -> timestamp_o jumps to 8.
- Mid-event reset: is_active_i=1 for 3 edges, then reset_i=1 for 1 edge with is_active_i still 1 -> timestamp_o=0. The next edges give 0,1,2,...
- Prescaler: TICK_DIV=4, is_active_i=1 continuously -> timestamp_o = 0,0,0,0,1,1,1,1,2...
- Wrap/saturate: SIZE=4, run 16 ticks -> counter_wrap_o pulses once as the count goes 15 -> 0 and the captured value returns to 0. With WALL_CLOCK_SATURATE_EN, the captured value sticks at 15 and counter_wrap_o pulses once, at the edge where the count reaches 15.

Source files
------------

// File: rtl/wall_clock.sv
// Free-running prescaled cycle counter with a level-gated timestamp capture register.
// Optional build macro WALL_CLOCK_SATURATE_EN: the counter saturates at all-ones instead of wrapping.
module wall_clock #(
    parameter int SIZE     = 32,
    parameter int TICK_DIV = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            is_active_i,
    output logic [SIZE-1:0] timestamp_o,
    output logic            timestamp_valid_o,
    output logic            counter_wrap_o
);

    localparam logic [15:0]     PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [SIZE-1:0] CNT_MAX    = {SIZE{1'b1}};
    localparam logic [SIZE-1:0] CNT_ONE    = SIZE'(1'b1);
    localparam logic [SIZE-1:0] CNT_PEN    = CNT_MAX - CNT_ONE;

    logic [15:0]     presc_q, presc_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] ts_q, ts_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic            tick_s;

    // Prescaler, counter and capture next-state logic
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        tick_s  = (presc_q == PRESC_LAST);

        if (tick_s) begin
            presc_d = 16'd0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

`ifdef WALL_CLOCK_SATURATE_EN
        // Pulse only on the tick that lands on all-ones; afterwards the count is frozen
        if (tick_s && (cnt_q != CNT_MAX)) begin
            cnt_d  = cnt_q + CNT_ONE;
            wrap_d = (cnt_q == CNT_PEN);
        end else begin
            cnt_d  = cnt_q;
            wrap_d = 1'b0;
        end
`else
        if (tick_s) begin
            cnt_d  = cnt_q + CNT_ONE;
            wrap_d = (cnt_q == CNT_MAX);
        end else begin
            cnt_d  = cnt_q;
            wrap_d = 1'b0;
        end
`endif

        // Capture the pre-increment count so a capture at edge k reports k-1
        if (is_active_i) begin
            ts_d    = cnt_q;
            valid_d = 1'b1;
        end else begin
            ts_d    = ts_q;
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset dominating all inputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= 16'd0;
            cnt_q   <= '0;
            ts_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign timestamp_o       = ts_q;
    assign timestamp_valid_o = valid_q;
    assign counter_wrap_o    = wrap_q;

endmodule

// File: tb/tb_wall_clock.sv
// Randomized self-checking bench for wall_clock: three parameterizations against an arithmetic reference model.
module tb_wall_clock;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic active = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] ts0;
    logic [7:0]  ts1;
    logic [3:0]  ts2;
    logic        v0, v1, v2, w0, w1, w2;

    wall_clock #(.SIZE(32), .TICK_DIV(1)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .is_active_i(active),
        .timestamp_o(ts0), .timestamp_valid_o(v0), .counter_wrap_o(w0));
    wall_clock #(.SIZE(8), .TICK_DIV(4)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .is_active_i(active),
        .timestamp_o(ts1), .timestamp_valid_o(v1), .counter_wrap_o(w1));
    wall_clock #(.SIZE(4), .TICK_DIV(1)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .is_active_i(active),
        .timestamp_o(ts2), .timestamp_valid_o(v2), .counter_wrap_o(w2));

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    // Reference state: edges since the last reset edge, plus expected outputs per instance
    longint unsigned edges = 0;
    longint unsigned exp_ts[3];
    logic            exp_v[3];
    logic            exp_w[3];
    int              td_a[3] = '{1, 4, 1};
    int              sz_a[3] = '{32, 8, 4};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    // Counter value after t edges since reset
    function automatic longint unsigned cnt_after(longint unsigned t, int td, int sz);
        longint unsigned ticks = t / longint'(td);
        longint unsigned modv  = 64'd1 << sz;
`ifdef WALL_CLOCK_SATURATE_EN
        return (ticks >= modv - 1) ? modv - 1 : ticks;
`else
        return ticks % modv;
`endif
    endfunction

    // Whether the edge numbered e (e>=1) produced a wrap/saturation pulse
    function automatic logic wrap_at(longint unsigned e, int td, int sz);
        longint unsigned modv = 64'd1 << sz;
        if (e == 0 || (e % longint'(td)) != 0) return 1'b0;
`ifdef WALL_CLOCK_SATURATE_EN
        return (e / longint'(td)) == modv - 1;
`else
        return ((e / longint'(td)) % modv) == 0;
`endif
    endfunction

    task automatic step(input logic rst, input logic act);
        reset  = rst;
        active = act;
        @(posedge clk);
        cycle++;
        if (rst) begin
            edges = 0;
            for (int i = 0; i < 3; i++) begin
                exp_ts[i] = 0;
                exp_v[i]  = 1'b0;
                exp_w[i]  = 1'b0;
            end
        end else begin
            edges++;
            for (int i = 0; i < 3; i++) begin
                if (act) exp_ts[i] = cnt_after(edges - 1, td_a[i], sz_a[i]);
                exp_v[i] = act;
                exp_w[i] = wrap_at(edges, td_a[i], sz_a[i]);
            end
        end
        @(negedge clk);
        check_eq("ts0", 64'(ts0), exp_ts[0]);
        check_eq("v0",  64'(v0),  64'(exp_v[0]));
        check_eq("w0",  64'(w0),  64'(exp_w[0]));
        check_eq("ts1", 64'(ts1), exp_ts[1]);
        check_eq("v1",  64'(v1),  64'(exp_v[1]));
        check_eq("w1",  64'(w1),  64'(exp_w[1]));
        check_eq("ts2", 64'(ts2), exp_ts[2]);
        check_eq("v2",  64'(v2),  64'(exp_v[2]));
        check_eq("w2",  64'(w2),  64'(exp_w[2]));
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 1'b0);
        check_eq("reset_ts", 64'(ts0), 64'd0);
        // Directed walk: 2 idle, 4 active, 2 idle, 1 active
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check_eq("capture_last", 64'(ts0), 64'd5);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("hold", 64'(ts0), 64'd5);
        step(1'b0, 1'b1);
        check_eq("idle_gap", 64'(ts0), 64'd8);
        // Mid-event reset with active held high
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_eq("mid_reset", 64'(ts0), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check_eq("post_reset", 64'(ts0), 64'd2);
        // Long continuous run covering prescaler and wrap on the small instances
        for (int i = 0; i < 1100; i++) step(1'b0, 1'b1);
        // Random activity with rare resets
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
